// File: rtl/axis_slave_matrix_loader.sv
// AXI-Stream ingress loader for the systolic multiplier.
// Buffers one A/B matrix-pair frame (SIZE A rows, then SIZE B rows) and then
// replays it as the diagonally skewed operand stream the array consumes.
module axis_slave_matrix_loader #(
  parameter int SIZE                 = 4,
  parameter int I_BITS               = 8,
  parameter int C_S_AXIS_TDATA_WIDTH = 32
) (
  input  logic                              i_clock,
  input  logic                              i_reset,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic                              s_axis_tlast,
  output logic                              o_mult_reset,
  output logic                              o_valid,
  output logic [SIZE*I_BITS-1:0]            o_a_full,
  output logic [SIZE*I_BITS-1:0]            o_b_full,
  output logic                              o_busy,
  output logic                              o_done,
  output logic                              o_frame_err
);

  localparam int ROW = SIZE * I_BITS;
  localparam int CW  = (SIZE > 2) ? $clog2(SIZE) : 1;
  localparam int SW  = $clog2(2 * SIZE);

  localparam logic [2:0] LOAD_A = 3'd0;
  localparam logic [2:0] LOAD_B = 3'd1;
  localparam logic [2:0] SKIP   = 3'd2;
  localparam logic [2:0] CLEAR  = 3'd3;
  localparam logic [2:0] STREAM = 3'd4;
  localparam logic [2:0] DRAIN  = 3'd5;
  localparam logic [2:0] DONE   = 3'd6;

  if (C_S_AXIS_TDATA_WIDTH != SIZE * I_BITS) begin : g_bad_width
    $error("C_S_AXIS_TDATA_WIDTH must equal SIZE*I_BITS");
  end
  if (SIZE < 2) begin : g_bad_size
    $error("SIZE must be at least 2");
  end

  logic [2:0]             state, state_d;
  logic [CW-1:0]          cnt, cnt_d;
  logic [SW-1:0]          step, step_d;
  logic                   beat, err_d, wr_a, wr_b;
  logic [SIZE*ROW-1:0]    a_flat, b_flat;
  logic [ROW-1:0]         a_vec_d, b_vec_d;
  logic                   unused_tstrb;

  assign unused_tstrb = ^s_axis_tstrb;
  assign beat         = s_axis_tvalid & s_axis_tready;

  // Next-state, beat counter and stream step decode
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    step_d  = step;
    err_d   = 1'b0;
    wr_a    = 1'b0;
    wr_b    = 1'b0;
    case (state)
      LOAD_A: if (beat) begin
        if (s_axis_tlast) begin
          err_d = 1'b1;
          cnt_d = '0;
        end else begin
          wr_a = 1'b1;
          if (cnt == CW'(SIZE - 1)) begin
            cnt_d   = '0;
            state_d = LOAD_B;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
      end
      LOAD_B: if (beat) begin
        if (cnt == CW'(SIZE - 1)) begin
          wr_b    = 1'b1;
          cnt_d   = '0;
          err_d   = ~s_axis_tlast;
          state_d = s_axis_tlast ? CLEAR : SKIP;
        end else if (s_axis_tlast) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = LOAD_A;
        end else begin
          wr_b  = 1'b1;
          cnt_d = cnt + 1'b1;
        end
      end
      SKIP: if (beat && s_axis_tlast) state_d = LOAD_A;
      CLEAR: begin
        step_d  = '0;
        state_d = STREAM;
      end
      STREAM: begin
        if (step == SW'(2 * SIZE - 2)) begin
          step_d  = '0;
          state_d = DRAIN;
        end else begin
          step_d = step + 1'b1;
        end
      end
      DRAIN: begin
        if (step == SW'(SIZE - 1)) begin
          step_d  = '0;
          state_d = DONE;
        end else begin
          step_d = step + 1'b1;
        end
      end
      DONE:    state_d = LOAD_A;
      default: state_d = LOAD_A;
    endcase
  end

  // Skewed operand selection for the step about to be presented:
  // lane q carries A[q][t-q] and B[t-q][q] when t-q lies inside the matrix.
  always_comb begin
    a_vec_d = '0;
    b_vec_d = '0;
    if (state_d == STREAM) begin
      for (int unsigned q = 0; q < SIZE; q++) begin
        for (int unsigned k = 0; k < SIZE; k++) begin
          if (32'(step_d) == q + k) begin
            a_vec_d[q*I_BITS +: I_BITS] = a_flat[(q*SIZE + k)*I_BITS +: I_BITS];
            b_vec_d[q*I_BITS +: I_BITS] = b_flat[(k*SIZE + q)*I_BITS +: I_BITS];
          end
        end
      end
    end
  end

  // Row buffers; intentionally not cleared by reset
  always_ff @(posedge i_clock) begin
    for (int unsigned r = 0; r < SIZE; r++) begin
      if (!i_reset && wr_a && cnt == CW'(r)) a_flat[r*ROW +: ROW] <= s_axis_tdata;
      if (!i_reset && wr_b && cnt == CW'(r)) b_flat[r*ROW +: ROW] <= s_axis_tdata;
    end
  end

  // State registers and outputs, registered from the next state so each
  // output lines up with the state it describes
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state         <= LOAD_A;
      cnt           <= '0;
      step          <= '0;
      s_axis_tready <= 1'b0;
      o_mult_reset  <= 1'b0;
      o_valid       <= 1'b0;
      o_a_full      <= '0;
      o_b_full      <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_frame_err   <= 1'b0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      step          <= step_d;
      s_axis_tready <= (state_d == LOAD_A) || (state_d == LOAD_B) || (state_d == SKIP);
      o_mult_reset  <= (state_d == CLEAR);
      o_valid       <= (state_d == STREAM) || (state_d == DRAIN);
      o_a_full      <= a_vec_d;
      o_b_full      <= b_vec_d;
      o_busy        <= (state_d != LOAD_A);
      o_done        <= (state_d == DONE);
      o_frame_err   <= err_d;
    end
  end

endmodule

// File: tb/tb_axis_slave_matrix_loader.sv
// Directed bench for axis_slave_matrix_loader (SIZE=4, I_BITS=8).
module tb_axis_slave_matrix_loader;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [31:0] s_axis_tdata = '0;
  logic [3:0]  s_axis_tstrb = 4'hF;
  logic        s_axis_tlast = 1'b0;
  logic        o_mult_reset, o_valid, o_busy, o_done, o_frame_err;
  logic [31:0] o_a_full, o_b_full;

  int vecs = 0;
  int errs = 0;

  logic [7:0] ma [4][4];
  logic [7:0] mb [4][4];

  // {tready, busy, mult_reset, valid, done, frame_err}
  logic [5:0] st;
  assign st = {s_axis_tready, o_busy, o_mult_reset, o_valid, o_done, o_frame_err};

  always #5 i_clock = ~i_clock;

  axis_slave_matrix_loader #(
    .SIZE(4),
    .I_BITS(8),
    .C_S_AXIS_TDATA_WIDTH(32)
  ) dut (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tstrb(s_axis_tstrb),
    .s_axis_tlast(s_axis_tlast),
    .o_mult_reset(o_mult_reset),
    .o_valid(o_valid),
    .o_a_full(o_a_full),
    .o_b_full(o_b_full),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_frame_err(o_frame_err)
  );

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  function automatic logic [31:0] row_of(input bit is_b, input int r);
    logic [31:0] v;
    for (int c = 0; c < 4; c++) v[c*8 +: 8] = is_b ? mb[r][c] : ma[r][c];
    return v;
  endfunction

  function automatic logic [31:0] exp_a(input int t);
    logic [31:0] v;
    v = '0;
    for (int q = 0; q < 4; q++) begin
      int k;
      k = t - q;
      if (k >= 0 && k < 4) v[q*8 +: 8] = ma[q][k];
    end
    return v;
  endfunction

  function automatic logic [31:0] exp_b(input int t);
    logic [31:0] v;
    v = '0;
    for (int q = 0; q < 4; q++) begin
      int k;
      k = t - q;
      if (k >= 0 && k < 4) v[q*8 +: 8] = mb[k][q];
    end
    return v;
  endfunction

  task automatic send_beat(input logic [31:0] d, input logic last);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    tick();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  // Send a full good frame (optionally with an idle cycle before each beat)
  // and check the complete CLEAR/STREAM/DRAIN/DONE sequence cycle by cycle.
  task automatic test_stream_frame(input bit gaps, input string tag);
    logic [5:0] want;
    for (int i = 0; i < 8; i++) begin
      if (gaps) begin
        tick();
        want = (i < 4) ? 6'b100000 : 6'b110000;
        vecs++;
        if (st !== want) begin
          errs++;
          $display("FAIL %s idle_hold beat=%0d got %b want %b", tag, i, st, want);
        end
      end
      send_beat(row_of(i >= 4, i % 4), i == 7);
      if (i < 7) begin
        want = (i >= 3) ? 6'b110000 : 6'b100000;
        vecs++;
        if (st !== want) begin
          errs++;
          $display("FAIL %s load beat=%0d got %b want %b", tag, i, st, want);
        end
      end
    end
    vecs++;
    if (st !== 6'b011000 || {o_a_full, o_b_full} !== 64'h0) begin
      errs++;
      $display("FAIL %s clear got st=%b a=%h b=%h want st=011000 a=0 b=0",
               tag, st, o_a_full, o_b_full);
    end
    for (int t = 0; t < 7; t++) begin
      tick();
      vecs++;
      if (st !== 6'b010100) begin
        errs++;
        $display("FAIL %s stream_status t=%0d got %b want 010100", tag, t, st);
      end
      vecs++;
      if (o_a_full !== exp_a(t) || o_b_full !== exp_b(t)) begin
        errs++;
        $display("FAIL %s stream_vec t=%0d got a=%h b=%h want a=%h b=%h",
                 tag, t, o_a_full, o_b_full, exp_a(t), exp_b(t));
      end
    end
    for (int d = 0; d < 4; d++) begin
      tick();
      vecs++;
      if (st !== 6'b010100 || {o_a_full, o_b_full} !== 64'h0) begin
        errs++;
        $display("FAIL %s drain d=%0d got st=%b a=%h b=%h want st=010100 a=0 b=0",
                 tag, d, st, o_a_full, o_b_full);
      end
    end
    tick();
    vecs++;
    if (st !== 6'b010010) begin
      errs++;
      $display("FAIL %s done got %b want 010010", tag, st);
    end
    tick();
    vecs++;
    if (st !== 6'b100000) begin
      errs++;
      $display("FAIL %s after_done got %b want 100000", tag, st);
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vecs++;
      if (st !== 6'b000000 || {o_a_full, o_b_full} !== 64'h0) begin
        errs++;
        $display("FAIL reset_hold cyc=%0d got st=%b a=%h b=%h want all 0", i, st, o_a_full, o_b_full);
      end
    end
    i_reset = 1'b0;
    tick();
    vecs++;
    if (st !== 6'b100000) begin
      errs++;
      $display("FAIL reset_release got %b want 100000", st);
    end
    tick();
    vecs++;
    if (st !== 6'b100000) begin
      errs++;
      $display("FAIL reset_idle got %b want 100000", st);
    end
  endtask

  task automatic set_counting_identity();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        ma[r][c] = 8'(4 * r + c + 1);
        mb[r][c] = (r == c) ? 8'd1 : 8'd0;
      end
  endtask

  task automatic test_matrix_frame();
    set_counting_identity();
    test_stream_frame(1'b0, "frame");
  endtask

  task automatic test_tvalid_gaps();
    set_counting_identity();
    test_stream_frame(1'b1, "gaps");
  endtask

  task automatic test_early_tlast();
    set_counting_identity();
    for (int i = 0; i < 3; i++) send_beat(row_of(1'b0, i), 1'b0);
    send_beat(row_of(1'b0, 3), 1'b1);
    vecs++;
    if (st !== 6'b100001) begin
      errs++;
      $display("FAIL early_tlast_err got %b want 100001", st);
    end
    tick();
    vecs++;
    if (st !== 6'b100000) begin
      errs++;
      $display("FAIL early_tlast_after got %b want 100000", st);
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        ma[r][c] = 8'(8'h20 + 4 * r + c);
        mb[r][c] = 8'(8'h40 + 4 * c + r);
      end
    test_stream_frame(1'b0, "after_err");
  endtask

  task automatic test_missing_tlast();
    set_counting_identity();
    for (int i = 0; i < 8; i++) send_beat(row_of(i >= 4, i % 4), 1'b0);
    vecs++;
    if (st !== 6'b110001) begin
      errs++;
      $display("FAIL skip_entry got %b want 110001", st);
    end
    send_beat(32'hDEAD_BEEF, 1'b0);
    vecs++;
    if (st !== 6'b110000) begin
      errs++;
      $display("FAIL skip_extra got %b want 110000", st);
    end
    send_beat(32'hCAFE_F00D, 1'b1);
    vecs++;
    if (st !== 6'b100000) begin
      errs++;
      $display("FAIL skip_exit got %b want 100000", st);
    end
    tick();
    vecs++;
    if (st !== 6'b100000) begin
      errs++;
      $display("FAIL skip_idle got %b want 100000", st);
    end
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        ma[r][c] = 8'(8'h10 * r + c);
        mb[r][c] = 8'(8'hF0 - 4 * r - c);
      end
    test_stream_frame(1'b0, "b2b_1");
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        ma[r][c] = 8'(8'hA0 + c * 8 + r);
        mb[r][c] = 8'(8'h05 + r * 16 + c * 3);
      end
    test_stream_frame(1'b0, "b2b_2");
  endtask

  task automatic test_reset_mid_stream();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        ma[r][c] = ((r + c) % 2 == 1) ? 8'h80 : 8'h7F;
        mb[r][c] = ((r + c) % 2 == 1) ? 8'h7F : 8'h80;
      end
    for (int i = 0; i < 8; i++) send_beat(row_of(i >= 4, i % 4), i == 7);
    for (int t = 0; t < 3; t++) begin
      tick();
      vecs++;
      if (o_valid !== 1'b1 || o_a_full !== exp_a(t) || o_b_full !== exp_b(t)) begin
        errs++;
        $display("FAIL signed_vec t=%0d got v=%b a=%h b=%h want v=1 a=%h b=%h",
                 t, o_valid, o_a_full, o_b_full, exp_a(t), exp_b(t));
      end
    end
    i_reset = 1'b1;
    tick();
    vecs++;
    if (st !== 6'b000000 || {o_a_full, o_b_full} !== 64'h0) begin
      errs++;
      $display("FAIL abort_reset got st=%b a=%h b=%h want all 0", st, o_a_full, o_b_full);
    end
    i_reset = 1'b0;
    tick();
    vecs++;
    if (st !== 6'b100000) begin
      errs++;
      $display("FAIL abort_release got %b want 100000", st);
    end
    for (int i = 0; i < 16; i++) begin
      tick();
      vecs++;
      if (st !== 6'b100000) begin
        errs++;
        $display("FAIL abort_quiet cyc=%0d got %b want 100000", i, st);
      end
    end
  endtask

  initial begin
    test_reset();
    test_matrix_frame();
    test_tvalid_gaps();
    test_early_tlast();
    test_missing_tlast();
    test_back_to_back();
    test_reset_mid_stream();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
